// File: rtl/timer_bank.sv
// Bank of NUM_CH prescaled down-counters behind a word-addressed bus slave.
// Each channel: CTRL/PRESET/COUNT/STATUS, one-shot or auto-reload, masked IRQ.
module timer_bank #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = 32,
    parameter logic [31:0] BASE   = 32'h0000_7f00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       addr,
    input  logic              we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [NUM_CH-1:0] irq_vec,
    output logic              irq
);
    localparam int unsigned BLK_W = 28;
    localparam int unsigned PSC_W = 8;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CNT, ST_INT} state_e;

    state_e             state_q   [NUM_CH];
    state_e             state_d   [NUM_CH];
    logic               en_q      [NUM_CH];
    logic               en_d      [NUM_CH];
    logic [1:0]         mode_q    [NUM_CH];
    logic [1:0]         mode_d    [NUM_CH];
    logic               im_q      [NUM_CH];
    logic               im_d      [NUM_CH];
    logic [PSC_W-1:0]   psc_q     [NUM_CH];
    logic [PSC_W-1:0]   psc_d     [NUM_CH];
    logic [PSC_W-1:0]   psc_cnt_q [NUM_CH];
    logic [PSC_W-1:0]   psc_cnt_d [NUM_CH];
    logic [WIDTH-1:0]   preset_q  [NUM_CH];
    logic [WIDTH-1:0]   preset_d  [NUM_CH];
    logic [WIDTH-1:0]   count_q   [NUM_CH];
    logic [WIDTH-1:0]   count_d   [NUM_CH];
    logic               pend_q    [NUM_CH];
    logic               pend_d    [NUM_CH];

    logic [BLK_W-1:0]   blk;
    logic               hit;
    logic [1:0]         reg_sel;
    logic               unused_bus_bits;

    // 16-byte block index relative to BASE; address bits [1:0] carry no meaning
    assign blk             = addr[31:4] - BASE[31:4];
    assign hit             = (addr[31:4] >= BASE[31:4]) && (blk < BLK_W'(NUM_CH));
    assign reg_sel         = addr[3:2];
    assign unused_bus_bits = ^{addr[1:0], wdata};

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c]   = state_q[c];
            en_d[c]      = en_q[c];
            mode_d[c]    = mode_q[c];
            im_d[c]      = im_q[c];
            psc_d[c]     = psc_q[c];
            psc_cnt_d[c] = psc_cnt_q[c];
            preset_d[c]  = preset_q[c];
            count_d[c]   = count_q[c];
            pend_d[c]    = pend_q[c];

            if (we && hit && (blk == BLK_W'(c))) begin
                case (reg_sel)
                    2'd0: begin
                        en_d[c]   = wdata[0];
                        mode_d[c] = wdata[2:1];
                        im_d[c]   = wdata[3];
                        psc_d[c]  = wdata[15:8];
                    end
                    2'd1:    preset_d[c] = wdata[WIDTH-1:0];
                    2'd3:    if (wdata[0]) pend_d[c] = 1'b0;
                    default: ;
                endcase
            end

            // Hardware updates come after the bus so a same-edge expiry beats W1C
            // and a one-shot EN clear beats a bus CTRL write.
            case (state_q[c])
                ST_IDLE: if (en_q[c]) state_d[c] = ST_LOAD;
                ST_LOAD: begin
                    count_d[c]   = preset_q[c];
                    psc_cnt_d[c] = '0;
                    state_d[c]   = ST_CNT;
                end
                ST_CNT: begin
                    if (!en_q[c]) begin
                        state_d[c] = ST_IDLE;
                    end else if (psc_cnt_q[c] == psc_q[c]) begin
                        psc_cnt_d[c] = '0;
                        if (count_q[c] != '0) begin
                            count_d[c] = count_q[c] - WIDTH'(1);
                        end else begin
                            pend_d[c]  = 1'b1;
                            state_d[c] = ST_INT;
                        end
                    end else begin
                        psc_cnt_d[c] = psc_cnt_q[c] + PSC_W'(1);
                    end
                end
                ST_INT: begin
                    if (mode_q[c] == 2'b01) begin
                        state_d[c] = ST_LOAD;
                    end else begin
                        en_d[c]    = 1'b0;
                        state_d[c] = ST_IDLE;
                    end
                end
                default: state_d[c] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (reset) begin
                state_q[c]   <= ST_IDLE;
                en_q[c]      <= 1'b0;
                mode_q[c]    <= '0;
                im_q[c]      <= 1'b0;
                psc_q[c]     <= '0;
                psc_cnt_q[c] <= '0;
                preset_q[c]  <= '0;
                count_q[c]   <= '0;
                pend_q[c]    <= 1'b0;
            end else begin
                state_q[c]   <= state_d[c];
                en_q[c]      <= en_d[c];
                mode_q[c]    <= mode_d[c];
                im_q[c]      <= im_d[c];
                psc_q[c]     <= psc_d[c];
                psc_cnt_q[c] <= psc_cnt_d[c];
                preset_q[c]  <= preset_d[c];
                count_q[c]   <= count_d[c];
                pend_q[c]    <= pend_d[c];
            end
        end
    end

    // Combinational read port; unimplemented bits and misses read zero
    always_comb begin
        rdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (hit && (blk == BLK_W'(c))) begin
                case (reg_sel)
                    2'd0:    rdata = {16'b0, psc_q[c], 4'b0, im_q[c], mode_q[c], en_q[c]};
                    2'd1:    rdata = 32'(preset_q[c]);
                    2'd2:    rdata = 32'(count_q[c]);
                    default: rdata = {31'b0, pend_q[c]};
                endcase
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            irq_vec[c] = pend_q[c] & im_q[c];
        end
    end

    assign irq = |irq_vec;

endmodule
